// File: rtl/bsg_link_pearl_pkg.sv
// Shared types for the link reset sequencer: the sequencer state encoding,
// the bundle of registered reset/status outputs, and a helper that maps each
// state to the output values it drives.
package bsg_link_pearl_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ASSERT_ALL  = 3'd1,
        S_TOKEN_HI    = 3'd2,
        S_TOKEN_LO    = 3'd3,
        S_IO_UP_REL   = 3'd4,
        S_IO_DOWN_REL = 3'd5,
        S_CORE_REL    = 3'd6,
        S_DONE        = 3'd7
    } bsg_link_reset_seq_state_e;

    typedef struct packed {
        logic io_uplink_reset;
        logic io_downlink_reset;
        logic async_token_reset;
        logic core_uplink_reset;
        logic core_downlink_reset;
        logic busy;
        logic done;
    } link_reset_outs_s;

    // Values held in reset and in IDLE: link fully held, token idle.
    localparam link_reset_outs_s ResetOuts = '{
        io_uplink_reset:     1'b1,
        io_downlink_reset:   1'b1,
        async_token_reset:   1'b0,
        core_uplink_reset:   1'b1,
        core_downlink_reset: 1'b1,
        busy:                1'b0,
        done:                1'b0
    };

    // Releases accumulate: each later state keeps every earlier release.
    function automatic link_reset_outs_s state_outputs(input bsg_link_reset_seq_state_e s);
        link_reset_outs_s o;
        o = ResetOuts;
        case (s)
            S_ASSERT_ALL:  o.busy = 1'b1;
            S_TOKEN_HI: begin
                o.busy              = 1'b1;
                o.async_token_reset = 1'b1;
            end
            S_TOKEN_LO:    o.busy = 1'b1;
            S_IO_UP_REL: begin
                o.busy            = 1'b1;
                o.io_uplink_reset = 1'b0;
            end
            S_IO_DOWN_REL: begin
                o.busy              = 1'b1;
                o.io_uplink_reset   = 1'b0;
                o.io_downlink_reset = 1'b0;
            end
            S_CORE_REL: begin
                o.busy                = 1'b1;
                o.io_uplink_reset     = 1'b0;
                o.io_downlink_reset   = 1'b0;
                o.core_uplink_reset   = 1'b0;
                o.core_downlink_reset = 1'b0;
            end
            S_DONE: begin
                o.done                = 1'b1;
                o.io_uplink_reset     = 1'b0;
                o.io_downlink_reset   = 1'b0;
                o.core_uplink_reset   = 1'b0;
                o.core_downlink_reset = 1'b0;
            end
            default: o = ResetOuts;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter used as the per-step timer. Saturates at zero.
// Ports: clk_i/reset_n_i (async active-low), set_i loads val_i,
//        down_i decrements when nonzero, count_o is the registered count.
module bsg_counter_set_down #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (set_i) begin
            count_q <= val_i;
        end else if (down_i && (count_q != '0)) begin
            count_q <= count_q - width_p'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_link_reset_sequencer.sv
// Sequences the resets of a BSG link: hold everything, pulse the token
// reset, then release IO uplink, IO downlink and core sides in turn, each
// step lasting W = max(wait_cycles_i,1) cycles captured at sequence start.
// Ports: clk_i, reset_n_i (async active-low), start_i, wait_cycles_i;
//        five active-high reset outputs plus busy_o / done_o, all registered.
module bsg_link_reset_sequencer
    import bsg_link_pearl_pkg::*;
#(
    parameter int unsigned cnt_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [cnt_width_p-1:0] wait_cycles_i,
    output logic                   io_uplink_reset_o,
    output logic                   io_downlink_reset_o,
    output logic                   async_token_reset_o,
    output logic                   core_uplink_reset_o,
    output logic                   core_downlink_reset_o,
    output logic                   busy_o,
    output logic                   done_o
);

    bsg_link_reset_seq_state_e state_q, state_d;
    logic [cnt_width_p-1:0]    w_q, w_d;
    logic [cnt_width_p-1:0]    cnt;
    logic [cnt_width_p-1:0]    w_eff_c;
    logic                      set_c;
    logic [cnt_width_p-1:0]    set_val_c;
    logic                      step_done_c;
    link_reset_outs_s          outs_q;

    // A zero wait request still gives one cycle per step.
    assign w_eff_c     = (wait_cycles_i == '0) ? cnt_width_p'(1) : wait_cycles_i;
    assign step_done_c = (cnt == '0);

    // Next-state logic; start_i is only looked at in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_ASSERT_ALL;
                    w_d     = w_eff_c;
                end
            end
            S_ASSERT_ALL:  if (step_done_c) state_d = S_TOKEN_HI;
            S_TOKEN_HI:    if (step_done_c) state_d = S_TOKEN_LO;
            S_TOKEN_LO:    if (step_done_c) state_d = S_IO_UP_REL;
            S_IO_UP_REL:   if (step_done_c) state_d = S_IO_DOWN_REL;
            S_IO_DOWN_REL: if (step_done_c) state_d = S_CORE_REL;
            S_CORE_REL:    if (step_done_c) state_d = S_DONE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Reload the timer with W-1 on every state change.
    assign set_c     = (state_d != state_q);
    assign set_val_c = w_d - cnt_width_p'(1);

    bsg_counter_set_down #(
        .width_p (cnt_width_p)
    ) u_step_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .set_i     (set_c),
        .val_i     (set_val_c),
        .down_i    (1'b1),
        .count_o   (cnt)
    );

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            outs_q  <= ResetOuts;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            outs_q  <= state_outputs(state_d);
        end
    end

    assign io_uplink_reset_o     = outs_q.io_uplink_reset;
    assign io_downlink_reset_o   = outs_q.io_downlink_reset;
    assign async_token_reset_o   = outs_q.async_token_reset;
    assign core_uplink_reset_o   = outs_q.core_uplink_reset;
    assign core_downlink_reset_o = outs_q.core_downlink_reset;
    assign busy_o                = outs_q.busy;
    assign done_o                = outs_q.done;

endmodule

// File: tb/tb_bsg_link_reset_sequencer.sv
// Self-checking bench for bsg_link_reset_sequencer: a timing model feeds a
// scoreboard every cycle, a vector table checks event cycles per wait value,
// and hand-written sequences cover re-start, mid-sequence reset and restart.
module tb_bsg_link_reset_sequencer;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] wait_c;
    logic io_up, io_dn, tok, core_up, core_dn, busy, done;

    always #5 clk = ~clk;

    bsg_link_reset_sequencer #(.cnt_width_p(CW)) dut (
        .clk_i                 (clk),
        .reset_n_i             (reset_n),
        .start_i               (start),
        .wait_cycles_i         (wait_c),
        .io_uplink_reset_o     (io_up),
        .io_downlink_reset_o   (io_dn),
        .async_token_reset_o   (tok),
        .core_uplink_reset_o   (core_up),
        .core_downlink_reset_o (core_dn),
        .busy_o                (busy),
        .done_o                (done)
    );

    typedef struct packed {
        logic io_up, io_dn, tok, core_up, core_dn, busy, done;
    } outs_t;

    typedef struct {
        logic [CW-1:0] w;
        int tok_on;
        int io_up_rel;
        int io_dn_rel;
        int core_rel;
        int done_at;
    } vec_t;

    outs_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 busy, 2 done; t counts cycles since ASSERT_ALL entry.
    int m_mode = 0;
    int m_t    = 0;
    int m_w    = 1;

    // Per-sequence event capture (cycle index relative to start edge).
    int cyc, ev_tok, ev_up, ev_dn, ev_core, ev_done;

    localparam outs_t IdleOuts = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    function automatic outs_t model_out();
        outs_t o;
        int ph;
        if (m_mode == 0) begin
            o = IdleOuts;
        end else if (m_mode == 2) begin
            o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            ph        = m_t / m_w;
            o.io_up   = (ph < 3);
            o.io_dn   = (ph < 4);
            o.core_up = (ph < 5);
            o.core_dn = (ph < 5);
            o.tok     = (ph == 1);
            o.busy    = 1'b1;
            o.done    = 1'b0;
        end
        return o;
    endfunction

    function automatic outs_t get_act();
        return outs_t'({io_up, io_dn, tok, core_up, core_dn, busy, done});
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %b expected %b (io_up io_dn tok core_up core_dn busy done)",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_events();
        cyc = 0; ev_tok = -1; ev_up = -1; ev_dn = -1; ev_core = -1; ev_done = -1;
    endtask

    // One clock: drive at negedge, push model expectation, compare after posedge.
    task automatic step(input logic s, input logic [CW-1:0] w);
        outs_t e, a;
        start  = s;
        wait_c = w;
        if (m_mode != 1 && s) begin
            m_mode = 1;
            m_t    = 0;
            m_w    = (w == 0) ? 1 : int'(w);
            clear_events();
        end else if (m_mode == 1) begin
            m_t++;
            if (m_t == 6 * m_w) m_mode = 2;
            cyc++;
        end else begin
            cyc++;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = get_act();
        check_outs("cycle", a, e);
        if (a.tok && ev_tok < 0)      ev_tok  = cyc;
        if (!a.io_up && ev_up < 0)    ev_up   = cyc;
        if (!a.io_dn && ev_dn < 0)    ev_dn   = cyc;
        if (!a.core_up && ev_core < 0) ev_core = cyc;
        if (a.done && ev_done < 0)    ev_done = cyc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        m_mode  = 0;
        #1;
        check_outs("reset_state", get_act(), IdleOuts);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t vecs[4];

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        wait_c  = '0;
        clear_events();

        vecs[0] = '{8'd3, 3, 9, 12, 15, 18};
        vecs[1] = '{8'd0, 1, 3, 4, 5, 6};
        vecs[2] = '{8'd1, 1, 3, 4, 5, 6};
        vecs[3] = '{8'd5, 5, 15, 20, 25, 30};

        // Idle after reset with no start.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, CW'($urandom_range(0, 255)));
        check_outs("idle_hold", get_act(), IdleOuts);

        // Vector table: event cycles for each wait value.
        foreach (vecs[v]) begin
            do_reset();
            step(1'b1, vecs[v].w);
            for (int c = 0; c < vecs[v].done_at + 2; c++)
                step(1'b0, CW'($urandom_range(0, 255)));
            check_int("tok_on",    ev_tok,  vecs[v].tok_on);
            check_int("io_up_rel", ev_up,   vecs[v].io_up_rel);
            check_int("io_dn_rel", ev_dn,   vecs[v].io_dn_rel);
            check_int("core_rel",  ev_core, vecs[v].core_rel);
            check_int("done_at",   ev_done, vecs[v].done_at);
        end

        // Start re-pulsed in TOKEN_LO (cycles 10..14 at W=5) is ignored.
        do_reset();
        step(1'b1, 8'd5);
        for (int c = 1; c < 35; c++) step(c == 11, (c == 11) ? 8'd9 : 8'd0);
        check_int("repulse_done_at", ev_done, 30);

        // Async reset during IO_DOWN_REL (cycles 12..14 at W=3).
        do_reset();
        step(1'b1, 8'd3);
        for (int c = 1; c <= 13; c++) step(1'b0, 8'd3);
        check_outs("pre_async", get_act(), '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        #2;
        reset_n = 1'b0;
        m_mode  = 0;
        #1;
        check_outs("async_reset", get_act(), IdleOuts);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'd2);
        step(1'b1, 8'd2);
        for (int c = 1; c <= 13; c++) step(1'b0, 8'd2);
        check_int("after_reset_done_at", ev_done, 12);

        // Restart from DONE re-asserts every link reset on the next cycle.
        step(1'b1, 8'd2);
        check_outs("restart_assert", get_act(), '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        for (int c = 1; c <= 13; c++) step(1'b0, 8'd7);
        check_int("restart_done_at", ev_done, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
